// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the hazard/stall controller and the pipeline datapath.
// With PIPE_CTRL_PERF_EN defined the bundle also carries the performance counters.
interface pipeline_ctrl_if;
    logic [4:0] ID_rs1_ind;
    logic [4:0] ID_rs2_ind;
    logic [4:0] EX_rd_ind;
    logic       EX_memread;
    logic       EX_branch_taken;
    logic       ID_hlt;
    logic       mem_busy;

    logic       pipe_en;
    logic       PC_write;
    logic       IF_ID_write;
    logic       IF_ID_FLUSH;
    logic       ID_EX_FLUSH;
    logic       EX_MEM_FLUSH;
    logic       MEM_WB_FLUSH;
    logic       halted;
    logic       mem_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
    logic [31:0] retire_cycles;
`endif

    // master is the controller, slave is the datapath it steers
    modport master (
        input  ID_rs1_ind, ID_rs2_ind, EX_rd_ind, EX_memread, EX_branch_taken, ID_hlt, mem_busy,
        output pipe_en, PC_write, IF_ID_write, IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH,
               halted, mem_timeout
`ifdef PIPE_CTRL_PERF_EN
        , output stall_cycles, flush_events, retire_cycles
`endif
    );

    modport slave (
        output ID_rs1_ind, ID_rs2_ind, EX_rd_ind, EX_memread, EX_branch_taken, ID_hlt, mem_busy,
        input  pipe_en, PC_write, IF_ID_write, IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH,
               halted, mem_timeout
`ifdef PIPE_CTRL_PERF_EN
        , input stall_cycles, flush_events, retire_cycles
`endif
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall/halt controller: load-use stalls, branch flushes, hlt drain, memory waits.
// Optional feature macro: PIPE_CTRL_PERF_EN adds stall/flush/retire performance counters.
module pipeline_ctrl (
    input  logic             clk,
    input  logic             rst,
    pipeline_ctrl_if.master  bus
);

    typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} state_t;

    state_t     state, state_next;
    state_t     saved, saved_next;
    logic [1:0] drain_cnt, drain_next;
    logic [7:0] wait_cnt, wait_next, wait_inc;
    logic       timeout, timeout_next;
    logic       load_use;

    logic pipe_en, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted;

    assign load_use = bus.EX_memread && (bus.EX_rd_ind != 5'd0) &&
                      ((bus.EX_rd_ind == bus.ID_rs1_ind) || (bus.EX_rd_ind == bus.ID_rs2_ind));

    assign wait_inc = (wait_cnt == 8'd255) ? 8'd255 : wait_cnt + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            saved     <= RUN;
            drain_cnt <= 2'd0;
            wait_cnt  <= 8'd0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_next;
            saved     <= saved_next;
            drain_cnt <= drain_next;
            wait_cnt  <= wait_next;
            timeout   <= timeout_next;
        end
    end

    // Memory stalls take priority over everything: the frozen pipeline keeps
    // the branch/hlt information in place, so it is re-evaluated on return.
    always_comb begin
        state_next   = state;
        saved_next   = saved;
        drain_next   = drain_cnt;
        wait_next    = wait_cnt;
        timeout_next = timeout;
        case (state)
            RUN: begin
                if (bus.mem_busy) begin
                    state_next = MEMWAIT;
                    saved_next = RUN;
                end else if (!bus.EX_branch_taken && !load_use && bus.ID_hlt) begin
                    state_next = DRAIN;
                    drain_next = 2'd3;
                end
            end
            DRAIN: begin
                if (bus.mem_busy) begin
                    state_next = MEMWAIT;
                    saved_next = DRAIN;
                end else if (bus.EX_branch_taken) begin
                    state_next = RUN;
                    drain_next = 2'd0;
                end else if (drain_cnt <= 2'd1) begin
                    state_next = HALTED;
                    drain_next = 2'd0;
                end else begin
                    drain_next = drain_cnt - 2'd1;
                end
            end
            MEMWAIT: begin
                if (bus.mem_busy) begin
                    wait_next = wait_inc;
                    if (wait_inc == 8'd255) timeout_next = 1'b1;
                end else begin
                    state_next = saved;
                    wait_next  = 8'd0;
                end
            end
            default: ;
        endcase
    end

    // While reset is held the datapath sees run defaults plus a flush of every stage.
    always_comb begin
        pipe_en      = 1'b1;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        halted       = 1'b0;
        if (rst) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else begin
            case (state)
                RUN, DRAIN: begin
                    if (bus.mem_busy) begin
                        pipe_en     = 1'b0;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                    end else if (bus.EX_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (state == DRAIN || load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                MEMWAIT: begin
                    pipe_en     = 1'b0;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                end
                HALTED: begin
                    halted      = 1'b1;
                    pipe_en     = 1'b0;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.pipe_en      = pipe_en;
    assign bus.PC_write     = pc_write;
    assign bus.IF_ID_write  = if_id_write;
    assign bus.IF_ID_FLUSH  = if_id_flush;
    assign bus.ID_EX_FLUSH  = id_ex_flush;
    assign bus.EX_MEM_FLUSH = ex_mem_flush;
    assign bus.MEM_WB_FLUSH = mem_wb_flush;
    assign bus.halted       = halted;
    assign bus.mem_timeout  = timeout;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_q, flush_q, retire_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= 32'd0;
            flush_q  <= 32'd0;
            retire_q <= 32'd0;
        end else begin
            if (state != HALTED && !pc_write) stall_q <= stall_q + 32'd1;
            if (if_id_flush) flush_q <= flush_q + 32'd1;
            if (pipe_en) retire_q <= retire_q + 32'd1;
        end
    end

    assign bus.stall_cycles  = stall_q;
    assign bus.flush_events  = flush_q;
    assign bus.retire_cycles = retire_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios then randomized traffic,
// all compared against a cycle-level behavioural model of the controller rules.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst;
    pipeline_ctrl_if bus ();

    pipeline_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model state: halted flag, remaining drain cycles, memory-wait flag and length, timeout.
    bit mHalted;
    int mDrainLeft;
    bit mMemWait;
    int mWait;
    bit mTimeout;
    bit [31:0] mStall, mFlush, mRetire;

    function automatic logic [8:0] observed();
        return {bus.pipe_en, bus.PC_write, bus.IF_ID_write, bus.IF_ID_FLUSH, bus.ID_EX_FLUSH,
                bus.EX_MEM_FLUSH, bus.MEM_WB_FLUSH, bus.halted, bus.mem_timeout};
    endfunction

    task automatic checkOutput(input string tag, input logic [8:0] expected);
        logic [8:0] obs;
        obs = observed();
        vectors++;
        assert (obs === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expected);
        end
`ifdef PIPE_CTRL_PERF_EN
        vectors++;
        assert ({bus.stall_cycles, bus.flush_events, bus.retire_cycles} === {mStall, mFlush, mRetire}) else begin
            miscompares++;
            $error("[TB] FAIL %s_perf observed=%0d/%0d/%0d expected=%0d/%0d/%0d", tag,
                   bus.stall_cycles, bus.flush_events, bus.retire_cycles, mStall, mFlush, mRetire);
        end
`endif
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic expected);
        vectors++;
        assert (obs === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expected);
        end
    endtask

    task automatic modelReset();
        mHalted = 0; mDrainLeft = 0; mMemWait = 0; mWait = 0; mTimeout = 0;
        mStall = 0; mFlush = 0; mRetire = 0;
    endtask

    // Starts just after a negedge; asserts reset, checks the reset outputs, releases it.
    task automatic doReset();
        rst = 1'b1;
        bus.ID_rs1_ind = 0; bus.ID_rs2_ind = 0; bus.EX_rd_ind = 0; bus.EX_memread = 0;
        bus.EX_branch_taken = 0; bus.ID_hlt = 0; bus.mem_busy = 0;
        #1;
        modelReset();
        checkOutput("reset", 9'b1_1_1_1_1_1_1_0_0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one cycle of inputs, checks outputs against the model, advances the model.
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input bit memread, input bit br, input bit hlt, input bit busy,
                                 input string tag);
        bit loadUse;
        logic [8:0] exp;
        bus.ID_rs1_ind = rs1; bus.ID_rs2_ind = rs2; bus.EX_rd_ind = rd; bus.EX_memread = memread;
        bus.EX_branch_taken = br; bus.ID_hlt = hlt; bus.mem_busy = busy;
        #1;
        loadUse = memread && rd != 0 && (rd == rs1 || rd == rs2);
        if (mHalted)                     exp = {8'b0000_0001, mTimeout};
        else if (mMemWait || busy)       exp = {8'b0000_0000, mTimeout};
        else if (br)                     exp = {8'b1111_1000, mTimeout};
        else if (mDrainLeft > 0 || loadUse) exp = {8'b1000_1000, mTimeout};
        else                             exp = {8'b1110_0000, mTimeout};
        checkOutput(tag, exp);
        if (!mHalted && !exp[7]) mStall++;
        if (exp[5]) mFlush++;
        if (exp[8]) mRetire++;
        if (mHalted) ;
        else if (mMemWait) begin
            if (busy) begin
                if (mWait < 255) mWait++;
                if (mWait == 255) mTimeout = 1;
            end else begin
                mMemWait = 0;
                mWait = 0;
            end
        end else if (busy) mMemWait = 1;
        else if (br) mDrainLeft = 0;
        else if (mDrainLeft > 0) begin
            mDrainLeft--;
            if (mDrainLeft == 0) mHalted = 1;
        end else if (hlt && !loadUse) mDrainLeft = 3;
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        rst = 1'b0;
        @(negedge clk);
        doReset();
        idle("run_defaults");

        // Load-use stall on rs2, then run defaults again
        applyStimulus(5'd1, 5'd5, 5'd5, 1, 0, 0, 0, "load_use_rs2");
        idle("after_load_use");
        applyStimulus(5'd0, 5'd0, 5'd0, 1, 0, 0, 0, "load_use_rd0");
        applyStimulus(5'd7, 5'd3, 5'd7, 1, 0, 0, 0, "load_use_rs1");
        applyStimulus(5'd7, 5'd3, 5'd7, 0, 0, 0, 0, "no_memread");
        applyStimulus(5'd1, 5'd5, 5'd5, 1, 1, 0, 0, "branch_over_load_use");
        applyStimulus(5'd1, 5'd5, 5'd5, 1, 0, 1, 0, "hlt_blocked_by_load_use");

        // hlt drain: 3 drain cycles then halted for 20 cycles, cleared by reset
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, "hlt");
        for (int i = 0; i < 3; i++) idle("drain");
        for (int i = 0; i < 20; i++) applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, (i % 3) == 0, "halted");
        #1 checkBit("halted_held", bus.halted, 1'b1);
        @(negedge clk);
        doReset();
        checkBit("halted_cleared", bus.halted, 1'b0);

        // Memory wait in the middle of a drain resumes the drain where it stopped
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, "hlt2");
        idle("drain3");
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, "drain_busy1");
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, "drain_busy2");
        idle("memwait_exit");
        idle("drain2_resumed");
        idle("drain1");
        idle("halted_after_wait");
        #1 checkBit("halted_after_wait_bit", bus.halted, 1'b1);
        @(negedge clk);
        doReset();

        // Speculative hlt cancelled by a taken branch during drain
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, "hlt3");
        idle("drain_spec");
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 1, 0, 0, "drain_branch");
        for (int i = 0; i < 4; i++) idle("run_after_cancel");

        // Long memory wait: timeout on the 256th wait cycle, sticky until reset
        for (int i = 0; i < 300; i++) applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, "long_wait");
        for (int i = 0; i < 3; i++) idle("after_timeout");
        #1 checkBit("timeout_sticky", bus.mem_timeout, 1'b1);
        @(negedge clk);
        doReset();
        checkBit("timeout_cleared", bus.mem_timeout, 1'b0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0 || (mHalted && $urandom_range(0, 9) == 0)) doReset();
            else applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                               bit'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
                               $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
